// File: rtl/i2c_result_harvest_pkg.sv
// rtl/i2c_result_harvest_pkg.sv - shared state encoding and result-quarter constants
package i2c_result_harvest_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FREEZE  = 3'd1,
        READ    = 3'd2,
        DRAIN   = 3'd3,
        RELEASE = 3'd4
    } harvest_state_e;

    // Upper address bits selecting the result quarter (0x800-0xbff) of the local bus
    localparam logic [1:0] RESULT_PREFIX = 2'b10;

    // One stream beat as stored in the output FIFO
    typedef struct packed {
        logic [7:0] data;
        logic [9:0] off;
        logic       last;
    } stream_beat_t;

    localparam int FIFO_W = $bits(stream_beat_t);

    function automatic logic [11:0] result_addr(input logic [9:0] off);
        return {RESULT_PREFIX, off};
    endfunction

endpackage

// File: rtl/i2c_result_harvest_if.sv
// rtl/i2c_result_harvest_if.sv - harvested byte stream handshake bundle
interface i2c_result_harvest_if;

    logic [7:0] m_data;
    logic [9:0] m_off;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data,
        output m_off,
        output m_last,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_off,
        input  m_last,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/i2c_result_harvest_fifo.sv
// rtl/i2c_result_harvest_fifo.sv - synchronous stream FIFO with a registered output stage
module harvest_fifo
    import i2c_result_harvest_pkg::*;
#(
    parameter int aw = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [FIFO_W-1:0] wr_data,
    output logic [aw:0]       free_slots,
    output logic [FIFO_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready
);

    localparam int          depth   = 1 << aw;
    localparam logic [aw:0] depth_w = (aw + 1)'(depth);

    logic [FIFO_W-1:0] mem_q [depth];
    logic [aw-1:0]     wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]     rd_ptr_q, rd_ptr_d;
    logic [aw:0]       cnt_q, cnt_d;
    logic [FIFO_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              mem_we, mem_re, bypass;

    // The output register refills from storage first, else straight from the write port,
    // so a write into an empty FIFO is visible on the very next cycle.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        mem_re      = 1'b0;
        bypass      = 1'b0;
        if (!out_valid_q || rd_ready) begin
            if (cnt_q != '0) begin
                out_d       = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                mem_re      = 1'b1;
            end else if (wr_valid) begin
                out_d       = wr_data;
                out_valid_d = 1'b1;
                bypass      = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        mem_we = wr_valid && !bypass;
        if (mem_we) wr_ptr_d = wr_ptr_q + 1'b1;
        if (mem_re) rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d = cnt_q + (aw + 1)'(mem_we) - (aw + 1)'(mem_re);
    end

    // Pointer, occupancy and output-stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= wr_data;
    end

    assign free_slots = depth_w - cnt_q;
    assign rd_data    = out_q;
    assign rd_valid   = out_valid_q;

endmodule

// File: rtl/i2c_result_harvest.sv
// rtl/i2c_result_harvest.sv - freezes the I2C result buffer, reads it out and streams the bytes
module i2c_result_harvest
    import i2c_result_harvest_pkg::*;
#(
    parameter int         len     = 32,
    parameter logic [9:0] base    = 10'h000,
    parameter int         fifo_aw = 2,
    parameter int         settle  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        updated,
    output logic                        freeze,
    output logic [11:0]                 lb_addr,
    output logic                        lb_write,
    input  logic [7:0]                  lb_dout,
    input  logic [11:0]                 host_addr,
    input  logic                        host_write,
    output logic                        host_wlost,
    i2c_result_harvest_if.master        m,
    output logic [15:0]                 frame_cnt,
    output logic                        busy
);

    localparam logic [10:0] last_idx    = 11'(len - 1);
    localparam logic [7:0]  settle_last = 8'(settle - 1);

    harvest_state_e state_q, state_d;
    logic [7:0]     settle_cnt_q, settle_cnt_d;
    logic [10:0]    idx_q, idx_d;
    logic           inflight_q, inflight_d;
    logic [9:0]     land_off_q, land_off_d;
    logic           land_last_q, land_last_d;
    logic           freeze_q, freeze_d;
    logic           host_wlost_q, host_wlost_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           busy_q, busy_d;

    logic [fifo_aw:0] fifo_free;
    logic [FIFO_W-1:0] fifo_rd_data;
    logic              fifo_rd_valid;
    stream_beat_t      wr_beat, rd_beat;
    logic [9:0]        rd_off;
    logic              issue;

    assign rd_off = base + idx_q[9:0];
    // A read is only launched when its byte is guaranteed a FIFO slot alongside the one already in flight
    assign issue  = (state_q == READ) && (fifo_free > (fifo_aw + 1)'(inflight_q));

    // Local-bus ownership: host in IDLE, harvester otherwise (host writes are dropped)
    always_comb begin
        if (state_q == IDLE) begin
            lb_addr  = host_addr;
            lb_write = host_write;
        end else begin
            lb_addr  = result_addr(rd_off);
            lb_write = 1'b0;
        end
    end

    // Harvest sequencing, issue counter and in-flight tracking
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        inflight_d   = issue;
        land_off_d   = rd_off;
        land_last_d  = issue && (idx_q == last_idx);
        host_wlost_d = host_wlost_q || (host_write && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (enable && updated) begin
                    state_d      = FREEZE;
                    settle_cnt_d = '0;
                    idx_d        = '0;
                end
            end
            FREEZE: begin
                if (settle_cnt_q == settle_last) state_d = READ;
                else settle_cnt_d = settle_cnt_q + 8'd1;
            end
            READ: begin
                if (issue) begin
                    idx_d = idx_q + 11'd1;
                    if (idx_q == last_idx) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_q && land_last_q) state_d = RELEASE;
            end
            RELEASE: begin
                if (!updated) begin
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        freeze_d = (state_d == FREEZE) || (state_d == READ) || (state_d == DRAIN);
        busy_d   = (state_d != IDLE);
    end

    // All control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            idx_q        <= '0;
            inflight_q   <= 1'b0;
            land_off_q   <= '0;
            land_last_q  <= 1'b0;
            freeze_q     <= 1'b0;
            host_wlost_q <= 1'b0;
            frame_cnt_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            idx_q        <= idx_d;
            inflight_q   <= inflight_d;
            land_off_q   <= land_off_d;
            land_last_q  <= land_last_d;
            freeze_q     <= freeze_d;
            host_wlost_q <= host_wlost_d;
            frame_cnt_q  <= frame_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_beat = '{data: lb_dout, off: land_off_q, last: land_last_q};

    harvest_fifo #(
        .aw (fifo_aw)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (inflight_q),
        .wr_data    (wr_beat),
        .free_slots (fifo_free),
        .rd_data    (fifo_rd_data),
        .rd_valid   (fifo_rd_valid),
        .rd_ready   (m.m_ready)
    );

    assign rd_beat    = fifo_rd_data;
    assign m.m_data   = rd_beat.data;
    assign m.m_off    = rd_beat.off;
    assign m.m_last   = rd_beat.last;
    assign m.m_valid  = fifo_rd_valid;

    assign freeze     = freeze_q;
    assign host_wlost = host_wlost_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_result_harvest.sv
// tb/tb_i2c_result_harvest.sv - self-checking bench for i2c_result_harvest
module tb_i2c_result_harvest;

    localparam int LEN_A  = 4;
    localparam int BASE_A = 'h3fe;
    localparam int LEN_B  = 32;
    localparam int BASE_B = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, updated, updated_b;
    logic [11:0] host_addr, hb_addr;
    logic        host_write, hb_write;
    logic        freeze_a, freeze_b, lb_write_a, lb_write_b;
    logic        host_wlost_a, host_wlost_b, busy_a, busy_b;
    logic [11:0] lb_addr_a, lb_addr_b;
    logic [7:0]  lb_dout_a, lb_dout_b;
    logic [15:0] frame_cnt_a, frame_cnt_b;

    int n_chk  = 0;
    int n_pass = 0;

    i2c_result_harvest_if sa ();
    i2c_result_harvest_if sb ();

    always #5 clk = ~clk;

    i2c_result_harvest #(
        .len (LEN_A), .base (10'h3fe), .fifo_aw (2), .settle (3)
    ) dut_a (
        .clk (clk), .rst (rst), .enable (enable), .updated (updated),
        .freeze (freeze_a), .lb_addr (lb_addr_a), .lb_write (lb_write_a), .lb_dout (lb_dout_a),
        .host_addr (host_addr), .host_write (host_write), .host_wlost (host_wlost_a),
        .m (sa.master), .frame_cnt (frame_cnt_a), .busy (busy_a)
    );

    i2c_result_harvest #(
        .len (LEN_B), .base (10'h000), .fifo_aw (2), .settle (3)
    ) dut_b (
        .clk (clk), .rst (rst), .enable (enable), .updated (updated_b),
        .freeze (freeze_b), .lb_addr (lb_addr_b), .lb_write (lb_write_b), .lb_dout (lb_dout_b),
        .host_addr (hb_addr), .host_write (hb_write), .host_wlost (host_wlost_b),
        .m (sb.master), .frame_cnt (frame_cnt_b), .busy (busy_b)
    );

    // Result memory contents: byte at offset o is o[7:0] ^ 0x5a
    function automatic logic [7:0] rdata(input logic [11:0] a);
        return (a[11:10] == 2'b10) ? (a[7:0] ^ 8'h5a) : 8'hee;
    endfunction

    // I2C block read port: data one cycle after the address
    always @(posedge clk) begin
        lb_dout_a <= rdata(lb_addr_a);
        lb_dout_b <= rdata(lb_addr_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Stream model: frame byte k carries offset (base+k) mod 1024, its memory byte, last on k=len-1
    int          ka = 0, kb = 0, xa = 0, xb = 0, oa, ob;
    logic        pa_hold = 1'b0, pb_hold = 1'b0;
    logic [18:0] pa_beat, pb_beat;

    always @(negedge clk) begin
        if (rst) begin
            ka = 0; kb = 0; pa_hold = 1'b0; pb_hold = 1'b0;
        end else begin
            if (freeze_a) check("a_freeze_implies_busy", busy_a, 1);
            if (freeze_b) check("b_freeze_implies_busy", busy_b, 1);
            if (pa_hold) begin
                check("a_hold_valid", sa.m_valid, 1);
                check("a_hold_beat", {sa.m_data, sa.m_off, sa.m_last}, pa_beat);
            end
            if (pb_hold) begin
                check("b_hold_valid", sb.m_valid, 1);
                check("b_hold_beat", {sb.m_data, sb.m_off, sb.m_last}, pb_beat);
            end
            if (sa.m_valid && sa.m_ready) begin
                oa = (BASE_A + ka) % 1024;
                check("a_m_off", sa.m_off, oa);
                check("a_m_data", sa.m_data, (oa % 256) ^ 'h5a);
                check("a_m_last", sa.m_last, ka == LEN_A - 1);
                ka = (ka + 1) % LEN_A;
                xa++;
            end
            if (sb.m_valid && sb.m_ready) begin
                ob = (BASE_B + kb) % 1024;
                check("b_m_off", sb.m_off, ob);
                check("b_m_data", sb.m_data, (ob % 256) ^ 'h5a);
                check("b_m_last", sb.m_last, kb == LEN_B - 1);
                kb = (kb + 1) % LEN_B;
                xb++;
            end
            pa_hold = sa.m_valid && !sa.m_ready;
            pa_beat = {sa.m_data, sa.m_off, sa.m_last};
            pb_hold = sb.m_valid && !sb.m_ready;
            pb_beat = {sb.m_data, sb.m_off, sb.m_last};
        end
    end

    logic [11:0] exp_addr [4] = '{12'hbfe, 12'hbff, 12'h800, 12'h801};
    logic [7:0]  exp_data [4] = '{8'ha4, 8'ha5, 8'h5a, 8'h5b};
    logic [9:0]  exp_off  [4] = '{10'h3fe, 10'h3ff, 10'h000, 10'h001};
    int last_iss, fall;
    logic seen_hi;

    initial begin
        rst = 1'b1; enable = 1'b0; updated = 1'b0; updated_b = 1'b0;
        host_addr = '0; host_write = 1'b0; hb_addr = '0; hb_write = 1'b0;
        sa.m_ready = 1'b1; sb.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_freeze", freeze_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_m_valid", sa.m_valid, 0);
        check("rst_m_last", sa.m_last, 0);
        check("rst_m_data", sa.m_data, 0);
        check("rst_m_off", sa.m_off, 0);
        check("rst_frame_cnt", frame_cnt_a, 0);
        check("rst_host_wlost", host_wlost_a, 0);
        check("rst_lb_write", lb_write_a, 0);
        check("rst_b_m_valid", sb.m_valid, 0);
        @(posedge clk); #1 rst = 1'b0;

        // enable low with updated high: stays idle, host owns the bus
        updated = 1'b1;
        for (int c = 0; c < 20; c++) begin
            host_addr  = 12'(c * 145 + 7);
            host_write = c[0];
            @(negedge clk);
            check("t6_lb_addr", lb_addr_a, host_addr);
            check("t6_lb_write", lb_write_a, host_write);
            check("t6_freeze", freeze_a, 0);
            check("t6_busy", busy_a, 0);
            @(posedge clk); #1;
        end
        host_write = 1'b0; updated = 1'b0; enable = 1'b1; host_addr = 12'h123;
        @(negedge clk);
        check("t6_host_wlost", host_wlost_a, 0);

        // single frame, len=4 at base 0x3fe (address wrap)
        @(posedge clk); #1 updated = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 0) updated = 1'b0;
            @(negedge clk);
            check("t1_freeze", freeze_a, c <= 7);
            check("t1_busy", busy_a, c <= 8);
            check("t1_m_valid", sa.m_valid, (c >= 5) && (c <= 8));
            if (c >= 3 && c <= 6) check("t1_lb_addr", lb_addr_a, exp_addr[c-3]);
            if (c >= 5 && c <= 8) begin
                check("t1_m_data", sa.m_data, exp_data[c-5]);
                check("t1_m_off", sa.m_off, exp_off[c-5]);
                check("t1_m_last", sa.m_last, c == 8);
            end
            if (c == 9) check("t1_frame_cnt", frame_cnt_a, 1);
        end

        // host write during READ, back-to-back frame, reset mid-READ
        @(posedge clk); #1 updated = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            host_write = (c == 4);
            if (c == 10) updated = 1'b0;
            if (c == 11) updated = 1'b1;
            if (c == 12) updated = 1'b0;
            rst = (c == 16);
            @(negedge clk);
            if (c == 3)  check("t3_lb_addr", lb_addr_a, 12'hbfe);
            if (c == 4)  check("t3_lb_write_gated", lb_write_a, 0);
            if (c == 5)  check("t3_host_wlost", host_wlost_a, 1);
            if (c == 7)  check("t4_freeze_drain", freeze_a, 1);
            if (c == 8)  check("t4_freeze_release", freeze_a, 0);
            if (c == 10) begin
                check("t4_busy_release", busy_a, 1);
                check("t4_frame_cnt_hold", frame_cnt_a, 1);
            end
            if (c == 11) begin
                check("t4_frame_cnt", frame_cnt_a, 2);
                check("t4_idle_gap_busy", busy_a, 0);
                check("t4_idle_gap_freeze", freeze_a, 0);
            end
            if (c == 12) check("t4_second_freeze", freeze_a, 1);
            if (c == 15) begin
                check("t5_lb_addr", lb_addr_a, 12'hbfe);
                check("t5_wlost_sticky", host_wlost_a, 1);
            end
            if (c == 17) begin
                check("t5_rst_freeze", freeze_a, 0);
                check("t5_rst_m_valid", sa.m_valid, 0);
                check("t5_rst_busy", busy_a, 0);
                check("t5_rst_frame_cnt", frame_cnt_a, 0);
                check("t5_rst_wlost", host_wlost_a, 0);
            end
        end

        // clean frame after reset
        @(posedge clk); #1 updated = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 0) updated = 1'b0;
            @(negedge clk);
            if (c == 5) begin
                check("t5b_m_valid", sa.m_valid, 1);
                check("t5b_m_off", sa.m_off, 10'h3fe);
            end
            if (c == 8) check("t5b_m_last", sa.m_last, 1);
            if (c == 9) begin
                check("t5b_frame_cnt", frame_cnt_a, 1);
                check("t5b_busy", busy_a, 0);
            end
        end

        // len=32 with a slow consumer (ready 1 cycle in 4)
        last_iss = -1; fall = -1; seen_hi = 1'b0;
        @(posedge clk); #1 updated_b = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (i == 0) updated_b = 1'b0;
            sb.m_ready = ((i % 4) == 3);
            @(negedge clk);
            if (freeze_b && lb_addr_b == 12'h81f) last_iss = i;
            if (freeze_b) seen_hi = 1'b1;
            else if (seen_hi && fall < 0) fall = i;
            if (xb >= 32 && fall >= 0) break;
        end
        check("t2_freeze_until_last_lands", fall, last_iss + 2);
        @(posedge clk); #1 sb.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t2_byte_count", xb, 32);
        check("t2_frame_cnt", frame_cnt_b, 1);
        check("t2_busy", busy_b, 0);
        check("t2_freeze", freeze_b, 0);
        check("a_byte_count", xa, 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
